// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - bf16/fp32 formats, constants and operand classification
package fp_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_NAN
  } fp_class_t;

  localparam logic [7:0]  FP32_BIAS    = 8'd127;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;
  localparam logic [31:0] FP32_POS_INF = 32'h7F800000;

  // Denormal inputs (exp=0, frac!=0) classify as zero: inputs are flushed.
  function automatic fp_class_t bf16_class(input bf16_t x);
    fp_class_t c;
    if (x.exp == 8'h00)
      c = CLS_ZERO;
    else if (x.exp == 8'hFF)
      c = (x.frac == 7'd0) ? CLS_INF : CLS_NAN;
    else
      c = CLS_NORM;
    return c;
  endfunction

endpackage

// File: rtl/fmul_bf16.sv
// rtl/fmul_bf16.sv - bf16 x bf16 -> fp32 multiplier, operand capture plus two compute stages
module fmul_bf16
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [31:0] mul_out
);

  logic        v0, v1;
  bf16_t       a0, b0;
  logic        s1, spec1;
  logic [15:0] p1;
  logic signed [9:0] e1;
  logic [31:0] spec_val1;

  fp_class_t   ca, cb;
  logic        s_c, spec_c;
  logic [15:0] p_c;
  logic signed [9:0] e_c;
  logic [31:0] spec_val_c;

  always_comb begin
    ca         = bf16_class(a0);
    cb         = bf16_class(b0);
    s_c        = a0.sign ^ b0.sign;
    p_c        = {1'b1, a0.frac} * {1'b1, b0.frac};
    e_c        = $signed({2'b00, a0.exp}) + $signed({2'b00, b0.exp})
               - $signed({2'b00, FP32_BIAS});
    spec_c     = 1'b1;
    spec_val_c = 32'h0;
    if (ca == CLS_NAN || cb == CLS_NAN)
      spec_val_c = FP32_QNAN;
    else if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF))
      spec_val_c = FP32_QNAN;
    else if (ca == CLS_INF || cb == CLS_INF)
      spec_val_c = {s_c, FP32_POS_INF[30:0]};
    else if (ca == CLS_ZERO || cb == CLS_ZERO)
      spec_val_c = {s_c, 31'b0};
    else
      spec_c = 1'b0;
  end

  logic signed [9:0] e_n;
  logic [22:0] frac_n;
  fp32_t       res_c;

  // Product is exact in 24 bits; only the leading-one position needs fixing.
  always_comb begin
    e_n    = p1[15] ? e1 + 10'sd1 : e1;
    frac_n = p1[15] ? {p1[14:0], 8'b0} : {p1[13:0], 9'b0};
    if (spec1)
      res_c = spec_val1;
    else if (e_n >= 10'sd255)
      res_c = '{sign: s1, exp: 8'hFF, frac: 23'b0};
    else if (e_n <= 10'sd0)
      res_c = '{sign: s1, exp: 8'h00, frac: 23'b0};
    else
      res_c = '{sign: s1, exp: e_n[7:0], frac: frac_n};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      mul_out   <= 32'h0;
    end else begin
      v0        <= in_valid;
      v1        <= v0;
      out_valid <= v1;
      if (v1)
        mul_out <= res_c;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      a0 <= a;
      b0 <= b;
    end
    if (v0) begin
      s1        <= s_c;
      p1        <= p_c;
      e1        <= e_c;
      spec1     <= spec_c;
      spec_val1 <= spec_val_c;
    end
  end

endmodule

// File: tb/tb_fmul_bf16.sv
// tb/tb_fmul_bf16.sv - vector table and scoreboard bench for fmul_bf16
module tb_fmul_bf16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        out_valid;
  logic [31:0] mul_out;

  always #5 clk = ~clk;

  fmul_bf16 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .mul_out(mul_out)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] y;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    int          due;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] last_y = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_result: got out_valid=1 mul_out=%h expected no result", mul_out);
      end else begin
        mon_e = sb.pop_front();
        check32("result", mul_out, mon_e.y);
        check32("latency_cycle", cyc, mon_e.due);
        last_y = mon_e.y;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] xa, input logic [15:0] xb, input logic [31:0] y);
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    sb.push_back('{y: y, due: cyc + 3});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 16'h0;
    b        = 16'h0;
    repeat (3) step();
    rst = 1'b0;
    check32("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check32("reset_mul_out", mul_out, 32'h0);

    vecs.push_back('{16'h3F80, 16'h3F80, 32'h3F800000});
    vecs.push_back('{16'h3FC0, 16'h3FC0, 32'h40100000});
    vecs.push_back('{16'hC000, 16'h4040, 32'hC0C00000});
    vecs.push_back('{16'h7F7F, 16'h7F7F, 32'h7F800000});
    vecs.push_back('{16'h0080, 16'h0080, 32'h00000000});
    vecs.push_back('{16'h8000, 16'h3F80, 32'h80000000});
    vecs.push_back('{16'h7F80, 16'h0000, 32'h7FC00000});
    vecs.push_back('{16'h7FC1, 16'h3F80, 32'h7FC00000});
    vecs.push_back('{16'hFF80, 16'h4000, 32'hFF800000});
    vecs.push_back('{16'hFF80, 16'hFF80, 32'h7F800000});
    vecs.push_back('{16'h0001, 16'h3F80, 32'h00000000});
    vecs.push_back('{16'h0000, 16'h7F80, 32'h7FC00000});
    vecs.push_back('{16'h7F81, 16'h0000, 32'h7FC00000});
    vecs.push_back('{16'h7F00, 16'h3F80, 32'h7F000000});
    vecs.push_back('{16'h7F00, 16'h4000, 32'h7F800000});
    vecs.push_back('{16'h0080, 16'h3F00, 32'h00000000});
    vecs.push_back('{16'h0080, 16'h3F80, 32'h00800000});
    vecs.push_back('{16'hBFC0, 16'h3FC0, 32'hC0100000});

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].y);
      step();
      in_valid = 1'b0;
      drain();
    end

    repeat (2) step();
    check32("hold_out_valid", {31'b0, out_valid}, 32'h0);
    check32("hold_mul_out", mul_out, last_y);

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].y);
      step();
    end
    in_valid = 1'b0;
    drain();

    issue(16'h3F80, 16'h3F80, 32'h3F800000);
    step();
    issue(16'h3FC0, 16'h3FC0, 32'h40100000);
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    check32("flush_out_valid", {31'b0, out_valid}, 32'h0);
    check32("flush_mul_out", mul_out, 32'h0);
    repeat (6) step();
    check32("post_flush_out_valid", {31'b0, out_valid}, 32'h0);
    check32("post_flush_mul_out", mul_out, 32'h0);

    issue(16'hC000, 16'h4040, 32'hC0C00000);
    step();
    in_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
